// File: rtl/sram_write_monitor_pkg.sv
// Shared types for sram_write_monitor: FSM states, MISR constants, step fn.
// No ports; imported by the top.
package sram_write_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MONITOR,
    S_DRAIN,
    S_SWEEP,
    S_DONE
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic [15:0] misr_step(
    input logic [15:0] sig,
    input logic [15:0] din
  );
    logic [15:0] fb;
    fb = sig[15] ? MISR_POLY : 16'h0000;
    return {sig[14:0], 1'b0} ^ fb ^ din;
  endfunction

endpackage

// File: rtl/sram_write_monitor_if.sv
// Observed SRAM write bus: we_n, address, write data.
// master drives the bus, slave (the monitor) observes it.
interface sram_write_monitor_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              sram_we_n;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_write_data;

  modport master (
    output sram_we_n, sram_address, sram_write_data
  );

  modport slave (
    input sram_we_n, sram_address, sram_write_data
  );
endinterface

// File: rtl/sram_write_monitor_write_bitmap.sv
// 1-bit x DEPTH simple dual-port RAM, one sync read, one write port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (registered read).
module write_bitmap #(
  parameter int DEPTH = 76800,
  parameter int IDX_W = 17
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic             wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic             rdata
);

  logic mem [DEPTH];

  // No reset: contents survive Resetn, only a clear pass zeroes them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sram_write_monitor.sv
// Watches SRAM writes: region check, duplicate bitmap, MISR, sweep.
// Ports: Clock, Resetn, start/region, bus (slave), sweep_req, status/counters.
module sram_write_monitor
  import sram_write_monitor_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 76800,
  parameter int CNT_W  = 18
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] region_base,
  input  logic [ADDR_W-1:0] region_limit,
  sram_write_monitor_if.slave bus,
  input  logic              sweep_req,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  write_count,
  output logic [CNT_W-1:0]  oor_count,
  output logic [CNT_W-1:0]  dup_count,
  output logic [CNT_W-1:0]  unwritten_count,
  output logic [15:0]       signature,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_t state, state_n;
  logic [IDX_W-1:0] cnt;
  logic drain_cnt;
  logic [ADDR_W-1:0] base_q, limit_q;

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic in_reg, wr;

  logic s_valid, s_inreg, s_fwd;
  logic [IDX_W-1:0] s_idx;
  logic [ADDR_W-1:0] s_addr;
  logic [15:0] s_data;

  logic rd, hit;
  logic bm_we, bm_wdata;
  logic [IDX_W-1:0] bm_waddr, bm_raddr;

  assign off = bus.sram_address - base_q;
  assign idx = IDX_W'(off);
  assign in_reg = (bus.sram_address >= base_q)
               && (bus.sram_address <= limit_q)
               && (32'(off) < 32'(DEPTH));
  assign wr = ~bus.sram_we_n && (state == S_MONITOR);
  assign hit = s_inreg && (rd || s_fwd);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = S_CLEAR;
    end else begin
      unique case (state)
        S_CLEAR:   if (cnt == LAST) state_n = S_MONITOR;
        S_MONITOR: if (sweep_req) state_n = S_DRAIN;
        S_DRAIN:   if (drain_cnt) state_n = S_SWEEP;
        S_SWEEP:   if (cnt == LAST) state_n = S_DONE;
        default:   ;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == S_CLEAR),
      (state == S_SWEEP): busy = 1'b1;
      (state == S_DONE):  done = 1'b1;
      default:            ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt       <= '0;
      drain_cnt <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      unique case (state)
        S_CLEAR, S_SWEEP:
          cnt <= (cnt == LAST) ? '0 : cnt + IDX_W'(1);
        S_DRAIN:
          drain_cnt <= ~drain_cnt;
        default:
          cnt <= '0;
      endcase
    end
  end

  // Sweep prefetches: the last drain cycle reads index 0, so
  // sweep cycle k sees mem[k] on rd.
  always_comb begin
    bm_we    = 1'b0;
    bm_wdata = 1'b0;
    bm_waddr = s_idx;
    bm_raddr = '0;
    if (state == S_CLEAR) begin
      bm_we    = 1'b1;
      bm_waddr = cnt;
    end else if (s_valid && s_inreg && !start) begin
      bm_we    = 1'b1;
      bm_wdata = 1'b1;
    end
    if (state == S_SWEEP)
      bm_raddr = (cnt == LAST) ? '0 : cnt + IDX_W'(1);
    else if (state == S_MONITOR && in_reg)
      bm_raddr = idx;
  end

  write_bitmap #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_bitmap (
    .clk   (Clock),
    .we    (bm_we),
    .waddr (bm_waddr),
    .wdata (bm_wdata),
    .raddr (bm_raddr),
    .rdata (rd)
  );

  // Stage 1. s_fwd covers a same-index write in stage 2, whose
  // bitmap update lands on the same edge as this read.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s_valid <= 1'b0;
      s_inreg <= 1'b0;
      s_fwd   <= 1'b0;
      s_idx   <= '0;
      s_addr  <= '0;
      s_data  <= '0;
    end else begin
      s_valid <= wr && !start;
      s_inreg <= in_reg;
      s_fwd   <= s_valid && s_inreg && in_reg
              && (s_idx == idx);
      s_idx   <= idx;
      s_addr  <= bus.sram_address;
      s_data  <= 16'(bus.sram_write_data);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      base_q          <= '0;
      limit_q         <= '0;
      write_count     <= '0;
      oor_count       <= '0;
      dup_count       <= '0;
      unwritten_count <= '0;
      signature       <= MISR_SEED;
      first_err_addr  <= '0;
      err_flag        <= 1'b0;
    end else if (start) begin
      base_q          <= region_base;
      limit_q         <= region_limit;
      write_count     <= '0;
      oor_count       <= '0;
      dup_count       <= '0;
      unwritten_count <= '0;
      signature       <= MISR_SEED;
      first_err_addr  <= '0;
      err_flag        <= 1'b0;
    end else begin
      if (s_valid) begin
        if (~&write_count)
          write_count <= write_count + CNT_W'(1);
        if (!s_inreg) begin
          oor_count <= oor_count + CNT_W'(1);
        end else begin
          signature <= misr_step(signature, s_data);
          if (hit) dup_count <= dup_count + CNT_W'(1);
        end
        if ((!s_inreg || hit) && !err_flag) begin
          first_err_addr <= s_addr;
          err_flag       <= 1'b1;
        end
      end
      if (state == S_SWEEP && !rd && ~&unwritten_count)
        unwritten_count <= unwritten_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sram_write_monitor.sv
// Bench: full-size DUT for clear/first-write/out-of-region, DEPTH=8 DUT for
// vector table, duplicates, sweep and reset-abort sequences.
module tb_sram_write_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  sram_write_monitor_if #(.ADDR_W(18), .DATA_W(16)) bb ();
  sram_write_monitor_if #(.ADDR_W(18), .DATA_W(16)) bs ();

  logic b_start, b_sweep;
  logic [17:0] b_base, b_limit;
  logic b_busy, b_done, b_err;
  logic [17:0] b_wc, b_oor, b_dup, b_unw, b_first;
  logic [15:0] b_sig;

  logic s_start, s_sweep;
  logic [17:0] s_base, s_limit;
  logic s_busy, s_done, s_err;
  logic [17:0] s_wc, s_oor, s_dup, s_unw, s_first;
  logic [15:0] s_sig;

  sram_write_monitor u_big (
    .Clock           (clk),
    .Resetn          (rst_n),
    .start           (b_start),
    .region_base     (b_base),
    .region_limit    (b_limit),
    .bus             (bb),
    .sweep_req       (b_sweep),
    .busy            (b_busy),
    .done            (b_done),
    .write_count     (b_wc),
    .oor_count       (b_oor),
    .dup_count       (b_dup),
    .unwritten_count (b_unw),
    .signature       (b_sig),
    .first_err_addr  (b_first),
    .err_flag        (b_err)
  );

  sram_write_monitor #(.DEPTH(8)) u_small (
    .Clock           (clk),
    .Resetn          (rst_n),
    .start           (s_start),
    .region_base     (s_base),
    .region_limit    (s_limit),
    .bus             (bs),
    .sweep_req       (s_sweep),
    .busy            (s_busy),
    .done            (s_done),
    .write_count     (s_wc),
    .oor_count       (s_oor),
    .dup_count       (s_dup),
    .unwritten_count (s_unw),
    .signature       (s_sig),
    .first_err_addr  (s_first),
    .err_flag        (s_err)
  );

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [15:0] data;
    logic [17:0] wc;
    logic [17:0] oor;
    logic [17:0] dup;
    logic [15:0] sig;
    logic        err;
    logic [17:0] first;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic s_write(input logic [17:0] a, input logic [15:0] d);
    bs.sram_we_n = 1'b0;
    bs.sram_address = a;
    bs.sram_write_data = d;
    tick();
    bs.sram_we_n = 1'b1;
  endtask

  task automatic s_begin(input logic [17:0] base, input logic [17:0] lim,
                         output int n);
    s_base = base;
    s_limit = lim;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n = 0;
    while (s_busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic s_sweep_wait(output int n);
    n = 0;
    while (!s_done && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{1, 18'd5,  16'h0000, 1, 0, 0, 16'hEFDF, 0, 0};
    tbl[1] = '{1, 18'd3,  16'h1234, 2, 1, 0, 16'hEFDF, 1, 3};
    tbl[2] = '{1, 18'd6,  16'h0001, 3, 1, 0, 16'hCF9E, 1, 3};
    tbl[3] = '{1, 18'd12, 16'h00FF, 4, 2, 0, 16'hCF9E, 1, 3};
    tbl[4] = '{1, 18'd5,  16'h0000, 5, 2, 1, 16'h8F1D, 1, 3};
    tbl[5] = '{1, 18'd21, 16'h0000, 6, 3, 1, 16'h8F1D, 1, 3};
    tbl[6] = '{1, 18'd11, 16'h8000, 7, 3, 1, 16'h8E1B, 1, 3};
    tbl[7] = '{1, 18'd4,  16'h00A5, 8, 3, 1, 16'h0CB2, 1, 3};
    tbl[8] = '{0, 18'd7,  16'hFFFF, 8, 3, 1, 16'h0CB2, 1, 3};

    b_start = 0; b_sweep = 0; b_base = 0; b_limit = 0;
    s_start = 0; s_sweep = 0; s_base = 0; s_limit = 0;
    bb.sram_we_n = 1; bb.sram_address = 0; bb.sram_write_data = 0;
    bs.sram_we_n = 1; bs.sram_address = 0; bs.sram_write_data = 0;

    tick(); tick();
    chk("rst_busy", {31'd0, b_busy}, 0);
    chk("rst_done", {31'd0, b_done}, 0);
    chk("rst_wc", 32'(b_wc), 0);
    chk("rst_sig", 32'(b_sig), 32'hFFFF);
    chk("rst_err", {31'd0, b_err}, 0);
    chk("rst_first", 32'(b_first), 0);
    rst_n = 1'b1;
    tick();

    // Full-size clear
    b_base = 0;
    b_limit = 18'd76799;
    b_start = 1;
    tick();
    b_start = 0;
    n = 0;
    while (b_busy && n < 80000) begin
      tick();
      n++;
    end
    chk("clear_cycles", 32'(n), 76800);
    chk("clear_done", {31'd0, b_done}, 0);
    chk("clear_wc", 32'(b_wc), 0);
    chk("clear_sig", 32'(b_sig), 32'hFFFF);

    // Single write, latency 2
    bb.sram_we_n = 0; bb.sram_address = 5; bb.sram_write_data = 0;
    tick();
    bb.sram_we_n = 1;
    chk("lat_wc_early", 32'(b_wc), 0);
    tick();
    chk("one_wc", 32'(b_wc), 1);
    chk("one_sig", 32'(b_sig), 32'hEFDF);
    chk("one_dup", 32'(b_dup), 0);
    chk("one_err", {31'd0, b_err}, 0);

    // Out of region at DEPTH
    bb.sram_we_n = 0; bb.sram_address = 18'd76800;
    bb.sram_write_data = 16'h1234;
    tick();
    bb.sram_we_n = 1;
    tick();
    chk("oor_cnt", 32'(b_oor), 1);
    chk("oor_first", 32'(b_first), 76800);
    chk("oor_err", {31'd0, b_err}, 1);
    chk("oor_sig", 32'(b_sig), 32'hEFDF);
    chk("oor_wc", 32'(b_wc), 2);

    // Vector table on DEPTH=8, region 4..20
    s_begin(18'd4, 18'd20, n);
    chk("s_clear_cycles", 32'(n), 8);
    for (int i = 0; i < 9; i++) begin
      bs.sram_we_n = ~tbl[i].we;
      bs.sram_address = tbl[i].addr;
      bs.sram_write_data = tbl[i].data;
      tick();
      bs.sram_we_n = 1;
      tick();
      chk($sformatf("v%0d_wc", i), 32'(s_wc), 32'(tbl[i].wc));
      chk($sformatf("v%0d_oor", i), 32'(s_oor), 32'(tbl[i].oor));
      chk($sformatf("v%0d_dup", i), 32'(s_dup), 32'(tbl[i].dup));
      chk($sformatf("v%0d_sig", i), 32'(s_sig), 32'(tbl[i].sig));
      chk($sformatf("v%0d_err", i), {31'd0, s_err}, {31'd0, tbl[i].err});
      chk($sformatf("v%0d_first", i), 32'(s_first), 32'(tbl[i].first));
    end

    s_sweep = 1;
    tick();
    s_sweep = 0;
    s_sweep_wait(n);
    chk("t_sweep_cycles", 32'(n), 10);
    chk("t_unwritten", 32'(s_unw), 4);
    s_sweep = 1;
    s_write(18'd8, 16'h5555);
    s_sweep = 0;
    tick(); tick();
    chk("done_hold", {31'd0, s_done}, 1);
    chk("done_wc", 32'(s_wc), 8);
    chk("done_sig", 32'(s_sig), 32'h0CB2);

    // Writes 0..5 back-to-back, sweep_req with the last write
    s_begin(18'd0, 18'd7, n);
    for (int a = 0; a < 5; a++) s_write(18'(a), 16'h0000);
    bs.sram_we_n = 0; bs.sram_address = 5; bs.sram_write_data = 0;
    s_sweep = 1;
    tick();
    bs.sram_we_n = 1;
    s_sweep = 0;
    s_sweep_wait(n);
    chk("sw_cycles", 32'(n), 10);
    chk("sw_unwritten", 32'(s_unw), 2);
    chk("sw_wc", 32'(s_wc), 6);
    chk("sw_dup", 32'(s_dup), 0);
    chk("sw_sig", 32'(s_sig), 32'h387C);

    // Duplicates: forwarded pair, gapped repeats
    s_begin(18'd0, 18'd7, n);
    chk("d_clear_cycles", 32'(n), 8);
    bs.sram_we_n = 0; bs.sram_address = 3; bs.sram_write_data = 0;
    tick();
    tick();
    bs.sram_we_n = 1;
    tick();
    chk("d_fwd_dup", 32'(s_dup), 1);
    chk("d_fwd_first", 32'(s_first), 3);
    tick(); tick(); tick();
    s_write(18'd3, 16'h0000);
    tick();
    s_write(18'd6, 16'h0000);
    tick();
    s_write(18'd6, 16'h0000);
    tick(); tick();
    chk("d_dup", 32'(s_dup), 3);
    chk("d_wc", 32'(s_wc), 5);
    chk("d_first", 32'(s_first), 3);
    chk("d_err", {31'd0, s_err}, 1);
    chk("d_oor", 32'(s_oor), 0);

    // Reset mid-sweep
    s_sweep = 1;
    tick();
    s_sweep = 0;
    tick(); tick(); tick(); tick();
    chk("m_in_sweep", {31'd0, s_busy}, 1);
    rst_n = 0;
    #1;
    chk("m_busy", {31'd0, s_busy}, 0);
    chk("m_done", {31'd0, s_done}, 0);
    chk("m_wc", 32'(s_wc), 0);
    chk("m_dup", 32'(s_dup), 0);
    chk("m_unw", 32'(s_unw), 0);
    chk("m_sig", 32'(s_sig), 32'hFFFF);
    tick();
    rst_n = 1;
    tick();
    s_write(18'd2, 16'h0000);
    tick(); tick();
    chk("m_idle_wc", 32'(s_wc), 0);
    s_begin(18'd0, 18'd7, n);
    chk("m_reclear", 32'(n), 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
